// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - core request and data-memory handshake bundle for the load/store unit
// slave is the LSU side; master is the core/memory side that drives requests and responses.
interface lsu_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] rdata;
    logic             dmem_req;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [3:0]       dmem_be;
    logic [WIDTH-1:0] dmem_wdata;
    logic             dmem_gnt;
    logic             dmem_rvalid;
    logic [WIDTH-1:0] dmem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output busy, done, err, rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  busy, done, err, rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: checks, issues and completes one data-memory access per request
// Rejected accesses complete in one cycle with err and never touch memory.
module lsu #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  reset,
    lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e           state_q;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic             dmem_req_q;
    logic             dmem_we_q;
    logic [WIDTH-1:0] dmem_addr_q;
    logic [3:0]       dmem_be_q;
    logic [WIDTH-1:0] dmem_wdata_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] rdata_q;

    logic             illegal;
    logic             misaligned;
    logic [3:0]       dmem_be_d;
    logic [WIDTH-1:0] dmem_wdata_d;
    logic [WIDTH-1:0] dmem_addr_d;
    logic [WIDTH-1:0] lane;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
        if (bus.req_we)
            illegal = bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'b11);
        else
            illegal = (bus.req_funct3 == 3'b011) | (bus.req_funct3[2:1] == 2'b11);

        case (bus.req_funct3[1:0])
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            default: misaligned = 1'b0;
        endcase

        // Sub-word stores replicate so every lane carries the data; be picks the real one.
        case (bus.req_funct3[1:0])
            2'b00: begin
                dmem_be_d    = 4'b0001 << bus.req_addr[1:0];
                dmem_wdata_d = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                dmem_be_d    = 4'b0011 << bus.req_addr[1:0];
                dmem_wdata_d = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                dmem_be_d    = 4'b1111;
                dmem_wdata_d = bus.req_wdata;
            end
        endcase

        dmem_addr_d = {bus.req_addr[WIDTH-1:2], 2'b00};
    end

    assign lane = bus.dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  rdata_d = {{(WIDTH-8){lane[7]}}, lane[7:0]};
            3'b100:  rdata_d = {{(WIDTH-8){1'b0}}, lane[7:0]};
            3'b001:  rdata_d = {{(WIDTH-16){lane[15]}}, lane[15:0]};
            3'b101:  rdata_d = {{(WIDTH-16){1'b0}}, lane[15:0]};
            default: rdata_d = lane;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.req_valid) begin
                        if (illegal || misaligned) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            we_q         <= bus.req_we;
                            funct3_q     <= bus.req_funct3;
                            off_q        <= bus.req_addr[1:0];
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= bus.req_we;
                            dmem_addr_q  <= dmem_addr_d;
                            dmem_be_q    <= dmem_be_d;
                            dmem_wdata_q <= dmem_wdata_d;
                            state_q      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        if (we_q) begin
                            err_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.dmem_rvalid) begin
                        rdata_q <= rdata_d;
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy       = bus.req_valid & ~done_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_be    = dmem_be_q;
    assign bus.dmem_wdata = dmem_wdata_q;
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-cycle RISC-V datapath: consumes the ALU sum (effective address), rs2 store data and funct3 in execute, and performs the data-memory access over a request/grant/response handshake. Produces the sign- or zero-extended load value for writeback. Holds the core stalled with `busy` until the access completes. Flags misaligned or illegal-width accesses instead of issuing them.

## Interface
- WIDTH, 32, datapath width; only 32 is supported (4 byte lanes)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  load/store in execute; held stable with other req_* until `done`
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- req_addr  in  WIDTH  byte address (ALU result)
- req_wdata  in  WIDTH  rs2 value
- busy  out  1  stall request to core, combinational: req_valid & ~done
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned or illegal funct3, no memory access made
- rdata  out  WIDTH  extended load data, valid with done on a load without err
- dmem_req  out  1  memory request
- dmem_we  out  1  write strobe
- dmem_addr  out  WIDTH  word address (req_addr with [1:0] = 00)
- dmem_be  out  4  byte enables
- dmem_wdata  out  WIDTH  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid, earliest one cycle after gnt
- dmem_rdata  in  WIDTH  read data word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on req_valid, check access:
  - Illegal: load funct3 ∈ {011,110,111}, store funct3 ≥ 011.
  - Misaligned: H/HU/SH with addr[0]=1, W/SW with addr[1:0]≠00.
  - Illegal or misaligned -> DONE with err=1, dmem_req stays 0.
  - Otherwise latch we, funct3, addr[1:0], dmem_addr, dmem_be, dmem_wdata -> REQ.
- REQ: dmem_req=1; dmem_* held stable until dmem_gnt. On gnt: store -> DONE, load -> WAIT.
- WAIT: on dmem_rvalid, register extended data into rdata -> DONE.
- DONE: done=1 for one cycle -> IDLE. Core advances at this edge; req_valid in the following cycle is a new access.
- Byte enables:
  - B: 0001 << addr[1:0]
  - H: 0011 << addr[1:0]
  - W: 1111
  - Loads drive the same be.
- Store data: SB replicates byte[7:0] to all four lanes; SH replicates [15:0] to both halves; SW passes through.
- Load extraction: lane = dmem_rdata >> (8*addr[1:0]).
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: unchanged.
- dmem_rvalid outside WAIT and dmem_gnt outside REQ are ignored.
- rdata and err hold their last values outside DONE; err is cleared on every non-err completion.

## Timing
- Reset values: state IDLE; dmem_req 0, dmem_we 0, dmem_addr 0, dmem_be 0, dmem_wdata 0, done 0, err 0, rdata 0.
- Reset mid-access (REQ/WAIT/DONE):
  - Immediately returns to IDLE and drops dmem_req asynchronously.
  - Pending response is discarded.
  - No done is produced.
- Store, gnt in first REQ cycle: req_valid seen at cycle 0, done at cycle 2.
- Load, gnt at cycle 1 and rvalid at cycle 2: done at cycle 3.
- Each gnt stall cycle adds one cycle; each rvalid wait cycle adds one cycle.
- Error access: done with err=1 at cycle 1.
- busy is high from the first req_valid cycle through the cycle before DONE, and low in the DONE cycle.

## Test plan
- SW addr 0x0000_1004, wdata 0xDEAD_BEEF, gnt immediate:
  - Cycle 1: dmem_req=1, dmem_addr=0x1004, be=1111, we=1, wdata=0xDEADBEEF.
  - Cycle 2: done=1, err=0.
- SB addr 0x0000_2003, wdata 0x0000_00A5:
  - be=1000, dmem_wdata=0xA5A5_A5A5.
  - Then SH addr 0x2002, wdata 0x1234: be=1100, dmem_wdata=0x1234_1234.
- LB addr 0x0000_3001, rdata 0x0000_8000, rvalid one cycle after gnt: rdata=0xFFFF_FF80, done at cycle 3. Same with LBU: rdata=0x0000_0080.
- LW addr 0x0000_4002: err=1, done at cycle 1, dmem_req never asserted. Load with funct3=011 behaves identically.
- Load with gnt held low 3 cycles, then rvalid after 2 more cycles:
  - dmem_addr/be stable throughout.
  - done exactly once, at cycle 7.
  - Spurious rvalid during REQ is ignored.
- Reset asserted during WAIT:
  - Outputs return to reset values in the same cycle.
  - A later rvalid is ignored.
  - The next req_valid after reset completes normally.
